// File: rtl/mem_arbiter_if.sv
// Bus between the two requesters (execute stage, loader/debug), the arbiter and data memory.
// The slave modport is the arbiter's view; master is the requester and memory side.
interface mem_arbiter_if #(
   parameter int unsigned LEN_REG       = 32,
   parameter int unsigned MEM_DATA_ADDR = 16
);
   logic                     req0, req1;
   logic                     we0, we1;
   logic                     lock0, lock1;
   logic [MEM_DATA_ADDR-1:0] addr0, addr1;
   logic [LEN_REG-1:0]       wdata0, wdata1;
   logic                     gnt0, gnt1;
   logic                     rvalid0, rvalid1;
   logic [LEN_REG-1:0]       rdata;
   logic [MEM_DATA_ADDR-1:0] mem_a;
   logic                     mem_w;
   logic [LEN_REG-1:0]       mem_d;
   logic [LEN_REG-1:0]       mem_q;

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_q,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_a, mem_w, mem_d
   );

   modport master (
      output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_q,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_a, mem_w, mem_d
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: round-robin on ties, optional locked bursts bounded by
// MAX_BURST, and fixed one-cycle load return through a shared rdata bus.
module mem_arbiter #(
   parameter int unsigned LEN_REG       = 32,
   parameter int unsigned MEM_DATA_ADDR = 16,
   parameter int unsigned MAX_BURST     = 8
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.slave  arb_if
);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   // cnt_q counts grants made while owning; the grant that entered ownership is the first.
   localparam logic [7:0] CntLast = 8'(MAX_BURST - 2);

   state_e     state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rvalid0_q, rvalid1_q;
   logic       gnt0, gnt1;
   logic       burst_end;

   assign burst_end = (cnt_q >= CntLast);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_if.req0 && (!arb_if.req1 || last_q)) begin
               gnt0 = 1'b1;
            end else if (arb_if.req1) begin
               gnt1 = 1'b1;
            end
            if ((gnt0 && arb_if.lock0) || (gnt1 && arb_if.lock1)) begin
               state_d = gnt0 ? StOwn0 : StOwn1;
               cnt_d   = '0;
            end
         end
         StOwn0: begin
            gnt0 = arb_if.req0;
            if (arb_if.req0) begin
               cnt_d = cnt_q + 8'd1;
            end
            if (!arb_if.req0 || !arb_if.lock0 || burst_end) begin
               state_d = StIdle;
            end
         end
         StOwn1: begin
            gnt1 = arb_if.req1;
            if (arb_if.req1) begin
               cnt_d = cnt_q + 8'd1;
            end
            if (!arb_if.req1 || !arb_if.lock1 || burst_end) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Grants must be low for the whole reset interval, not just after the next edge.
      if (!rst_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      if (gnt0) begin
         last_d = 1'b0;
      end else if (gnt1) begin
         last_d = 1'b1;
      end
   end

   always_comb begin
      arb_if.mem_a = '0;
      arb_if.mem_d = '0;
      arb_if.mem_w = 1'b0;
      if (gnt0) begin
         arb_if.mem_a = arb_if.addr0;
         arb_if.mem_d = arb_if.wdata0;
         arb_if.mem_w = arb_if.we0;
      end else if (gnt1) begin
         arb_if.mem_a = arb_if.addr1;
         arb_if.mem_d = arb_if.wdata1;
         arb_if.mem_w = arb_if.we1;
      end
   end

   assign arb_if.gnt0    = gnt0;
   assign arb_if.gnt1    = gnt1;
   assign arb_if.rvalid0 = rvalid0_q;
   assign arb_if.rvalid1 = rvalid1_q;
   assign arb_if.rdata   = (rvalid0_q || rvalid1_q) ? arb_if.mem_q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         rvalid0_q <= gnt0 && !arb_if.we0;
         rvalid1_q <= gnt1 && !arb_if.we1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset corner cases and
// randomized traffic checked against a grant-level reference model.
module tb_mem_arbiter;

   localparam int unsigned LEN = 32;
   localparam int unsigned AW  = 16;
   localparam int unsigned MB  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.LEN_REG(LEN), .MEM_DATA_ADDR(AW)) bus ();

   mem_arbiter #(.LEN_REG(LEN), .MEM_DATA_ADDR(AW), .MAX_BURST(MB)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (bus)
   );

   // Behavioural data memory: registered read, unwritten words read back a fixed pattern.
   logic [31:0] mem [256];
   bit          written [256];

   function automatic logic [31:0] init_pat(input logic [7:0] a);
      return 32'hC0DE_0000 | {24'd0, a};
   endfunction

   function automatic logic [31:0] mem_val(input logic [7:0] a);
      return written[a] ? mem[a] : init_pat(a);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_w) begin
         mem[bus.mem_a[7:0]]     <= bus.mem_d;
         written[bus.mem_a[7:0]] <= 1'b1;
      end
      bus.mem_q <= mem_val(bus.mem_a[7:0]);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: owner -1 = nobody, burst = grants in the current locked run.
   int          m_owner;
   int unsigned m_burst;
   int          m_last;
   bit          m_rv0, m_rv1;
   logic [31:0] m_rd;
   int          c_g;
   bit          c_rv0, c_rv1;
   logic [31:0] c_rd;

   // Values seen at the last sample point, used by the directed checks.
   bit          s_g0, s_g1, s_mw, s_rv0, s_rv1;
   logic [15:0] s_ma;
   logic [31:0] s_rd;

   bit cnt_en = 1'b0;
   int n_loadg = 0;
   int n_rv    = 0;

   task automatic model_reset();
      m_owner = -1;
      m_burst = 0;
      m_last  = 1;
      m_rv0   = 1'b0;
      m_rv1   = 1'b0;
      m_rd    = '0;
   endtask

   task automatic model_check();
      logic        rq [2];
      int          g;
      logic [15:0] ea;
      logic [31:0] ed;
      logic        ew;
      rq[0] = bus.req0;
      rq[1] = bus.req1;
      if (m_owner >= 0)            g = rq[m_owner] ? m_owner : -1;
      else if (rq[0] && rq[1])     g = 1 - m_last;
      else if (rq[0])              g = 0;
      else if (rq[1])              g = 1;
      else                         g = -1;
      ea = (g == 0) ? bus.addr0  : (g == 1) ? bus.addr1  : 16'd0;
      ed = (g == 0) ? bus.wdata0 : (g == 1) ? bus.wdata1 : 32'd0;
      ew = (g == 0) ? bus.we0    : (g == 1) ? bus.we1    : 1'b0;
      chk("m_gnt0", bus.gnt0, g == 0);
      chk("m_gnt1", bus.gnt1, g == 1);
      chk("m_mem_a", bus.mem_a, ea);
      chk("m_mem_d", bus.mem_d, ed);
      chk("m_mem_w", bus.mem_w, ew);
      chk("m_rvalid0", bus.rvalid0, m_rv0);
      chk("m_rvalid1", bus.rvalid1, m_rv1);
      chk("m_rdata", bus.rdata, (m_rv0 || m_rv1) ? m_rd : 32'd0);
      c_g   = g;
      c_rv0 = (g == 0) && !bus.we0;
      c_rv1 = (g == 1) && !bus.we1;
      c_rd  = mem_val(ea[7:0]);
   endtask

   task automatic model_update();
      bit lk [2];
      lk[0] = bus.lock0;
      lk[1] = bus.lock1;
      m_rv0 = c_rv0;
      m_rv1 = c_rv1;
      m_rd  = c_rd;
      if (c_g >= 0) m_last = c_g;
      if (m_owner >= 0) begin
         if (c_g < 0) begin
            m_owner = -1;
         end else begin
            m_burst++;
            if (!lk[m_owner] || m_burst >= MB) m_owner = -1;
         end
      end else if (c_g >= 0 && lk[c_g]) begin
         m_owner = c_g;
         m_burst = 1;
      end
   endtask

   // ctl = {req0, req1, we0, we1, lock0, lock1}
   task automatic step(input logic [5:0] ctl, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
      {bus.req0, bus.req1, bus.we0, bus.we1, bus.lock0, bus.lock1} = ctl;
      bus.addr0  = a0;
      bus.addr1  = a1;
      bus.wdata0 = d0;
      bus.wdata1 = d1;
      @(negedge clk);
      s_g0 = bus.gnt0;   s_g1 = bus.gnt1;   s_mw = bus.mem_w; s_ma = bus.mem_a;
      s_rv0 = bus.rvalid0; s_rv1 = bus.rvalid1; s_rd = bus.rdata;
      model_check();
      if (cnt_en) begin
         chk("one_gnt", bus.gnt0 & bus.gnt1, 1'b0);
         chk("gnt_without_req", (bus.gnt0 & ~bus.req0) | (bus.gnt1 & ~bus.req1), 1'b0);
         n_loadg += int'(bus.gnt0 && !bus.we0) + int'(bus.gnt1 && !bus.we1);
         n_rv    += int'(bus.rvalid0) + int'(bus.rvalid1);
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   typedef struct {
      logic [5:0]  ctl;  // {r0, r1, w0, w1, l0, l1}
      logic [15:0] a0;
      logic [15:0] a1;
      logic [31:0] d0;
      logic [4:0]  ex;   // {gnt0, gnt1, mem_w, rvalid0, rvalid1}
      logic [15:0] ema;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl [20];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Tie, store/load, 8-grant locked burst, lock release after 3, round-robin into OWN1.
      tbl[0]  = '{6'b110000, 16'd5, 16'd9, 32'd0,      5'b10000, 16'd5, 32'd0};
      tbl[1]  = '{6'b110000, 16'd5, 16'd9, 32'd0,      5'b01010, 16'd9, 32'hC0DE0005};
      tbl[2]  = '{6'b000000, 16'd5, 16'd9, 32'd0,      5'b00001, 16'd0, 32'hC0DE0009};
      tbl[3]  = '{6'b101000, 16'd3, 16'd0, 32'hA5A5,   5'b10100, 16'd3, 32'd0};
      tbl[4]  = '{6'b100000, 16'd3, 16'd0, 32'd0,      5'b10000, 16'd3, 32'd0};
      tbl[5]  = '{6'b000000, 16'd3, 16'd0, 32'd0,      5'b00010, 16'd0, 32'h0000A5A5};
      tbl[6]  = '{6'b110001, 16'd1, 16'd2, 32'd0,      5'b01000, 16'd2, 32'd0};
      for (int k = 7; k <= 13; k++) begin
         tbl[k] = '{6'b110001, 16'd1, 16'd2, 32'd0,    5'b01001, 16'd2, 32'hC0DE0002};
      end
      tbl[14] = '{6'b110010, 16'd1, 16'd2, 32'd0,      5'b10001, 16'd1, 32'hC0DE0002};
      tbl[15] = '{6'b110010, 16'd1, 16'd2, 32'd0,      5'b10010, 16'd1, 32'hC0DE0001};
      tbl[16] = '{6'b110010, 16'd1, 16'd2, 32'd0,      5'b10010, 16'd1, 32'hC0DE0001};
      tbl[17] = '{6'b110000, 16'd1, 16'd2, 32'd0,      5'b10010, 16'd1, 32'hC0DE0001};
      tbl[18] = '{6'b110001, 16'd1, 16'd2, 32'd0,      5'b01010, 16'd2, 32'hC0DE0001};
      tbl[19] = '{6'b110001, 16'd1, 16'd2, 32'd0,      5'b01001, 16'd2, 32'hC0DE0002};

      model_reset();
      {bus.req0, bus.req1, bus.we0, bus.we1, bus.lock0, bus.lock1} = 6'b110000;
      bus.addr0 = 16'd5; bus.addr1 = 16'd9; bus.wdata0 = '0; bus.wdata1 = '0;
      #2;
      chk("rst_gnt0", bus.gnt0, 1'b0);
      chk("rst_gnt1", bus.gnt1, 1'b0);
      chk("rst_mem_w", bus.mem_w, 1'b0);
      chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 2'b00);
      chk("rst_rdata", bus.rdata, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].ctl, tbl[i].a0, tbl[i].a1, tbl[i].d0, 32'd0);
         chk($sformatf("vec%0d_gnt0", i), s_g0, tbl[i].ex[4]);
         chk($sformatf("vec%0d_gnt1", i), s_g1, tbl[i].ex[3]);
         chk($sformatf("vec%0d_mem_w", i), s_mw, tbl[i].ex[2]);
         chk($sformatf("vec%0d_rvalid0", i), s_rv0, tbl[i].ex[1]);
         chk($sformatf("vec%0d_rvalid1", i), s_rv1, tbl[i].ex[0]);
         chk($sformatf("vec%0d_mem_a", i), s_ma, tbl[i].ema);
         chk($sformatf("vec%0d_rdata", i), s_rd,
             (tbl[i].ex[1] || tbl[i].ex[0]) ? tbl[i].erd : 32'd0);
      end

      // Reset mid-burst: port 1 owns the bus with a load just returned and req1 still high.
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt1", bus.gnt1, 1'b0);
      chk("midrst_rvalid1", bus.rvalid1, 1'b0);
      chk("midrst_rdata", bus.rdata, 32'd0);
      chk("midrst_mem_a", bus.mem_a, 16'd0);
      model_reset();
      @(posedge clk);
      #1;
      chk("midrst_hold_gnt", {bus.gnt0, bus.gnt1}, 2'b00);
      rst_n = 1'b1;
      step(6'b110000, 16'd5, 16'd9, 32'd0, 32'd0);
      chk("postrst_tie_gnt0", s_g0, 1'b1);
      chk("postrst_tie_gnt1", s_g1, 1'b0);
      step(6'b000000, 16'd0, 16'd0, 32'd0, 32'd0);
      chk("postrst_rvalid0", s_rv0, 1'b1);

      cnt_en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] ctl;
         ctl[5] = ($urandom_range(0, 3) != 0);
         ctl[4] = ($urandom_range(0, 3) != 0);
         ctl[3] = ($urandom_range(0, 3) == 0);
         ctl[2] = ($urandom_range(0, 3) == 0);
         ctl[1] = ($urandom_range(0, 7) != 0);
         ctl[0] = ($urandom_range(0, 7) != 0);
         step(ctl, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), $urandom, $urandom);
      end
      step(6'b000000, 16'd0, 16'd0, 32'd0, 32'd0);
      chk("rvalid_count_vs_load_grants", n_rv, n_loadg);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LEN_REG, default 32, data word width; the block SHALL take it from the shared instruction definitions.
REQ-002 Parameter MEM_DATA_ADDR, default 16, data memory address width.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive grants to one locked port; legal range 2..255.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req0, req1  input  1 each  access request; port 0 is the execute stage, port 1 is the loader/debug port.
REQ-007 we0, we1  input  1 each  1 = store, 0 = load.
REQ-008 addr0, addr1  input  MEM_DATA_ADDR each  word address.
REQ-009 wdata0, wdata1  input  LEN_REG each  store data.
REQ-010 lock0, lock1  input  1 each  request to keep ownership for the next cycle.
REQ-011 gnt0, gnt1  output  1 each  access accepted this cycle; combinational.
REQ-012 rvalid0, rvalid1  output  1 each  load data valid on rdata; registered.
REQ-013 rdata  output  LEN_REG  load return data, shared by both ports.
REQ-014 mem_a, mem_w, mem_d  output  MEM_DATA_ADDR/1/LEN_REG  drive memory_data A/W/D.
REQ-015 mem_q  input  LEN_REG  memory_data Q; valid one cycle after the address.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high in any cycle, and gntN SHALL only be high when reqN is high.
REQ-017 The granted port's addr SHALL drive mem_a and its wdata SHALL drive mem_d in the same cycle; mem_w SHALL equal the granted port's we.
REQ-018 With no grant, mem_w SHALL be 0 and mem_a/mem_d SHALL be 0.
REQ-019 States: IDLE, OWN0, OWN1. A grant in IDLE SHALL go to OWN0/OWN1 if the granted port's lock is high, otherwise stay in IDLE.
REQ-020 Arbitration in IDLE:
- If only one port requests, that port SHALL be granted.
- If both request, the port not granted most recently SHALL be granted (round-robin using a last-grant register).
REQ-021 In OWNn, port n SHALL have absolute priority. Requests from the other port SHALL be held off (gnt low) while port n requests.
REQ-022 In OWNn, the block SHALL return to IDLE after the current cycle when any of these holds: locknn is low, reqn is low (no grant that cycle), or the burst counter reaches MAX_BURST.
REQ-023 Burst counter:
- Clears on entry to OWNn.
- Increments on each OWNn grant.
- On reaching MAX_BURST, the next cycle SHALL be IDLE with last-grant = n, so a waiting other port wins.
REQ-024 rvalidn SHALL be high exactly one cycle after a load grant to port n, with rdata = mem_q in that cycle. Otherwise rvalidn SHALL be 0 and rdata SHALL be 0.
REQ-025 Stores SHALL produce no rvalid.
REQ-026 Back-to-back loads SHALL sustain one grant per cycle; rvalid SHALL follow each grant with fixed 1-cycle latency, including across ownership changes.
REQ-027 The last-grant register SHALL update on every grant.

Reset
REQ-028 While rst_n is low: state = IDLE, last-grant = 1 (port 0 wins the first tie), burst counter = 0, rvalid0 = rvalid1 = 0, rdata = 0, gnt0 = gnt1 = 0, mem_w = 0.
REQ-029 Reset asserted mid-burst SHALL abort ownership immediately; no rvalid SHALL be emitted for a load granted in the cycle before reset.
REQ-030 The first grant after deassertion SHALL occur on the first rising edge cycle with rst_n high.

Verification
REQ-031 Tie after reset: req0 = req1 = 1, both we = 0, addr0 = 5, addr1 = 9 -> cycle 1 gnt0, mem_a = 5; cycle 2 gnt1, mem_a = 9, rvalid0 = 1 with rdata = mem[5]; cycle 3 rvalid1 = 1.
REQ-032 Store then load: port 0 stores 0xA5A5 at addr 3, then loads addr 3 -> mem_w = 1 only in the store cycle; rvalid0 next cycle after the load with rdata = 0xA5A5.
REQ-033 Lock starvation bound: port 1 holds req1 = lock1 = 1, port 0 requests continuously, MAX_BURST = 8 -> exactly 8 consecutive gnt1, then gnt0 on the 9th cycle.
REQ-034 Lock release: lock0 drops after 3 grants while req1 is pending -> the fourth port-0 grant is the last in OWN0, and the next cycle grants port 1.
REQ-035 Reset mid-burst: rst_n pulled low during OWN1 with a load in flight -> gnt and rvalid go 0 immediately; after release, a tie grants port 0 first.
REQ-036 Randomized check: at most one gnt per cycle, a grant only with its req, and rvalid count equal to load-grant count.
